ex_mem_stage: RTL

//   Execute-to-memory pipeline stage sitting directly downstream of the ALU core.

---
 rtl/ex_mem_stage_if.sv | 47 ++++
 rtl/ex_mem_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/ex_mem_stage_if.sv
// Signal bundle between the EX stage, the EX/MEM stage and the MEM stage.
// The slave modport is the stage itself; the master modport drives it.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  dest_reg;
  logic              ctl_branch;
  logic              ctl_branch_ne;
  logic              ctl_mem_read;
  logic              ctl_mem_write;
  logic              ctl_reg_write;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] branch_offset;
  logic              flush_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_dest_reg;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_reg_write;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;

  modport master (
    output in_valid, alu_result, alu_zero, store_data, dest_reg, ctl_branch, ctl_branch_ne,
           ctl_mem_read, ctl_mem_write, ctl_reg_write, pc_plus4, branch_offset, flush_in,
           out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_dest_reg, out_mem_read,
           out_mem_write, out_reg_write, branch_taken, branch_target
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, store_data, dest_reg, ctl_branch, ctl_branch_ne,
           ctl_mem_read, ctl_mem_write, ctl_reg_write, pc_plus4, branch_offset, flush_in,
           out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_dest_reg, out_mem_read,
           out_mem_write, out_reg_write, branch_taken, branch_target
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: resolves BEQ/BNE and passes all other instructions
// to the memory stage through a 2-entry skid buffer.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest_reg;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } entry_t;

  state_t            state_reg, state_next;
  entry_t            head_reg, head_next;
  entry_t            skid_reg, skid_next;
  entry_t            in_entry;
  logic              branch_taken_reg, branch_taken_next;
  logic [DATA_W-1:0] branch_target_reg, branch_target_next;
  logic              in_ready, accept, accept_data, accept_branch, xfer;

  assign in_ready      = (state_reg != TWO);
  assign accept        = bus.in_valid & in_ready & ~bus.flush_in;
  assign accept_data   = accept & ~bus.ctl_branch;
  assign accept_branch = accept & bus.ctl_branch;
  assign xfer          = (state_reg != EMPTY) & bus.out_ready;

  always_comb begin
    in_entry            = '0;
    in_entry.result     = bus.alu_result;
    in_entry.store_data = bus.store_data;
    in_entry.dest_reg   = bus.dest_reg;
    in_entry.mem_read   = bus.ctl_mem_read;
    in_entry.mem_write  = bus.ctl_mem_write;
    in_entry.reg_write  = bus.ctl_reg_write;
  end

  always_comb begin
    state_next         = state_reg;
    head_next          = head_reg;
    skid_next          = skid_reg;
    branch_taken_next  = accept_branch & (bus.alu_zero ^ bus.ctl_branch_ne);
    branch_target_next = branch_target_reg;
    if (accept_branch) begin
      branch_target_next = bus.pc_plus4 + (bus.branch_offset << 2);
    end

    case (state_reg)
      EMPTY: begin
        if (accept_data) begin
          state_next = ONE;
          head_next  = in_entry;
        end
      end
      ONE: begin
        // Simultaneous drain and fill keeps one entry: the new one becomes head.
        if (accept_data && xfer) begin
          head_next = in_entry;
        end else if (accept_data) begin
          state_next = TWO;
          skid_next  = in_entry;
        end else if (xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          state_next = ONE;
          head_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase

    // A draining transfer still completes; everything left behind is discarded.
    if (bus.flush_in) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= EMPTY;
      head_reg          <= '0;
      skid_reg          <= '0;
      branch_taken_reg  <= 1'b0;
      branch_target_reg <= '0;
    end else begin
      state_reg         <= state_next;
      head_reg          <= head_next;
      skid_reg          <= skid_next;
      branch_taken_reg  <= branch_taken_next;
      branch_target_reg <= branch_target_next;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_reg != EMPTY);
  assign bus.out_result     = head_reg.result;
  assign bus.out_store_data = head_reg.store_data;
  assign bus.out_dest_reg   = head_reg.dest_reg;
  assign bus.out_mem_read   = head_reg.mem_read;
  assign bus.out_mem_write  = head_reg.mem_write;
  assign bus.out_reg_write  = head_reg.reg_write;
  assign bus.branch_taken   = branch_taken_reg;
  assign bus.branch_target  = branch_target_reg;

endmodule
